// File: rtl/dct8_row_engine.sv
// 8-point HEVC integer DCT/IDCT row engine with rounding, saturation and block framing.
// Latency 4 cycles, 1 row/cycle; a single advance enable freezes every stage while the output is held.
module dct8_row_engine #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12,
  parameter int SHIFT = 6,
  parameter int ROWS  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_mode,
  input  logic [8*IN_W-1:0]  i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [8*OUT_W-1:0] o_data,
  output logic               o_last,
  output logic               o_sat
);

  localparam int ACC_W = IN_W + 10;
  localparam int RND_W = (ACC_W > OUT_W) ? ACC_W + 1 : OUT_W + 1;
  localparam int CNT_W = $clog2(ROWS);

  localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(1 << (SHIFT - 1));
  localparam logic signed [RND_W-1:0] SAT_MAX  = RND_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RND_W-1:0] SAT_MIN  = ~SAT_MAX;

  localparam logic signed [7:0] C [8][8] = '{
    '{8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64},
    '{8'sd89,  8'sd75,  8'sd50,  8'sd18, -8'sd18, -8'sd50, -8'sd75, -8'sd89},
    '{8'sd83,  8'sd36, -8'sd36, -8'sd83, -8'sd83, -8'sd36,  8'sd36,  8'sd83},
    '{8'sd75, -8'sd18, -8'sd89, -8'sd50,  8'sd50,  8'sd89,  8'sd18, -8'sd75},
    '{8'sd64, -8'sd64, -8'sd64,  8'sd64,  8'sd64, -8'sd64, -8'sd64,  8'sd64},
    '{8'sd50, -8'sd89,  8'sd18,  8'sd75, -8'sd75, -8'sd18,  8'sd89, -8'sd50},
    '{8'sd36, -8'sd83,  8'sd83, -8'sd36, -8'sd36,  8'sd83, -8'sd83,  8'sd36},
    '{8'sd18, -8'sd50,  8'sd75, -8'sd89,  8'sd89, -8'sd75,  8'sd50, -8'sd18}
  };

  logic                    en;
  logic                    s1_vld, s2_vld, s3_vld;
  logic                    s1_mode;
  logic signed [IN_W-1:0]  s1_x   [8];
  logic signed [ACC_W-1:0] s2_lo  [8];
  logic signed [ACC_W-1:0] s2_hi  [8];
  logic signed [ACC_W-1:0] s3_acc [8];
  logic signed [ACC_W-1:0] lo_c   [8];
  logic signed [ACC_W-1:0] hi_c   [8];
  logic signed [RND_W-1:0] rnd_c  [8];
  logic [8*OUT_W-1:0]      res_c;
  logic                    clip_c;
  logic [CNT_W-1:0]        cnt;

  assign en      = !o_valid || i_ready;
  assign o_ready = en;
  assign o_last  = o_valid && (cnt == CNT_W'(ROWS - 1));

  // Inverse mode uses the transposed matrix; the two half-sums are registered to split the adder tree.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lo_c[i] = '0;
      hi_c[i] = '0;
      for (int j = 0; j < 4; j++) begin
        lo_c[i] = lo_c[i] + ACC_W'(s1_x[j])     * ACC_W'(s1_mode ? C[j][i]     : C[i][j]);
        hi_c[i] = hi_c[i] + ACC_W'(s1_x[j + 4]) * ACC_W'(s1_mode ? C[j + 4][i] : C[i][j + 4]);
      end
    end
  end

  always_comb begin
    res_c  = '0;
    clip_c = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rnd_c[k] = (RND_W'(s3_acc[k]) + RND_HALF) >>> SHIFT;
      if (rnd_c[k] > SAT_MAX) begin
        res_c[k*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
        clip_c = 1'b1;
      end else if (rnd_c[k] < SAT_MIN) begin
        res_c[k*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
        clip_c = 1'b1;
      end else begin
        res_c[k*OUT_W +: OUT_W] = rnd_c[k][OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s3_vld  <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sat   <= 1'b0;
      cnt     <= '0;
    end else begin
      if (en) begin
        s1_vld  <= i_valid;
        s2_vld  <= s1_vld;
        s3_vld  <= s2_vld;
        o_valid <= s3_vld;
        o_data  <= res_c;
        if (s3_vld && clip_c) o_sat <= 1'b1;
      end
      if (o_valid && i_ready) cnt <= (cnt == CNT_W'(ROWS - 1)) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Datapath payload carries no reset; the valid bits above qualify it.
  always_ff @(posedge i_clk) begin
    if (en) begin
      s1_mode <= i_mode;
      for (int n = 0; n < 8; n++) begin
        s1_x[n]   <= i_data[n*IN_W +: IN_W];
        s2_lo[n]  <= lo_c[n];
        s2_hi[n]  <= hi_c[n];
        s3_acc[n] <= s2_lo[n] + s2_hi[n];
      end
    end
  end

endmodule
